// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: default widths and entry layout for the L1I fetch queue.
package fetch_queue_pkg;
   localparam int QUEUE_DEPTH     = 16;
   localparam int STALL_THRESHOLD = 6;
   localparam int FETCH_ADDR_W    = 64;
   localparam int INSTR_W         = 32;
   localparam int PID_W           = 20;
   localparam int TID_W           = 16;
   localparam int MAJOR_ID_W      = 64;

   typedef struct packed {
      logic [INSTR_W-1:0]      instruction;
      logic [FETCH_ADDR_W-1:0] address;
      logic [PID_W-1:0]        pid;
      logic [TID_W-1:0]        tid;
      logic [MAJOR_ID_W-1:0]   major_id;
   } fq_entry_t;

   localparam int ENTRY_W = $bits(fq_entry_t);
endpackage

// File: rtl/fetch_queue_storage.sv
// fetch_queue_storage: unreset register array, 2 write ports and 2 combinational read ports.
module fetch_queue_storage #(
   parameter int DEPTH = 16,
   parameter int DW    = 8
) (
   input  logic                     i_clk,
   input  logic                     i_we0,
   input  logic                     i_we1,
   input  logic [$clog2(DEPTH)-1:0] i_wa0,
   input  logic [$clog2(DEPTH)-1:0] i_wa1,
   input  logic [DW-1:0]            i_wd0,
   input  logic [DW-1:0]            i_wd1,
   input  logic [$clog2(DEPTH)-1:0] i_ra0,
   input  logic [$clog2(DEPTH)-1:0] i_ra1,
   output logic [DW-1:0]            o_rd0,
   output logic [DW-1:0]            o_rd1
);
   logic [DW-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we0) r_mem[i_wa0] <= i_wd0;
      if (i_we1) r_mem[i_wa1] <= i_wd1;
   end

   assign o_rd0 = r_mem[i_ra0];
   assign o_rd1 = r_mem[i_ra1];
endmodule

// File: rtl/l1i_fetch_queue.sv
// l1i_fetch_queue: 2-in/2-out in-order instruction fetch queue with cache back-pressure.
// FETCH_QUEUE_PERF_EN builds the stall/empty cycle counters; otherwise they read 0.
module l1i_fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int queueDepth              = QUEUE_DEPTH,
   parameter int stallThreshold          = STALL_THRESHOLD,
   parameter int fetchingAddressWidth    = FETCH_ADDR_W,
   parameter int instructionWidth        = INSTR_W,
   parameter int PidSize                 = PID_W,
   parameter int TidSize                 = TID_W,
   parameter int instructionCounterWidth = MAJOR_ID_W
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               flush_i,
   input  logic                               fetchEnable1_i,
   input  logic                               fetchEnable2_i,
   input  logic [instructionWidth-1:0]        fetchedInstruction1_i,
   input  logic [instructionWidth-1:0]        fetchedInstruction2_i,
   input  logic [fetchingAddressWidth-1:0]    fetchedAddress1_i,
   input  logic [fetchingAddressWidth-1:0]    fetchedAddress2_i,
   input  logic [PidSize-1:0]                 fetchedPid1_i,
   input  logic [PidSize-1:0]                 fetchedPid2_i,
   input  logic [TidSize-1:0]                 fetchedTid1_i,
   input  logic [TidSize-1:0]                 fetchedTid2_i,
   input  logic [instructionCounterWidth-1:0] fetchedInstMajorId1_i,
   input  logic [instructionCounterWidth-1:0] fetchedInstMajorId2_i,
   output logic                               fetchStall_o,
   input  logic [1:0]                         decodePop_i,
   output logic                               decodeValid1_o,
   output logic                               decodeValid2_o,
   output logic [instructionWidth-1:0]        decodeInstruction1_o,
   output logic [instructionWidth-1:0]        decodeInstruction2_o,
   output logic [fetchingAddressWidth-1:0]    decodeAddress1_o,
   output logic [fetchingAddressWidth-1:0]    decodeAddress2_o,
   output logic [PidSize-1:0]                 decodePid1_o,
   output logic [PidSize-1:0]                 decodePid2_o,
   output logic [TidSize-1:0]                 decodeTid1_o,
   output logic [TidSize-1:0]                 decodeTid2_o,
   output logic [instructionCounterWidth-1:0] decodeInstMajorId1_o,
   output logic [instructionCounterWidth-1:0] decodeInstMajorId2_o,
   output logic [$clog2(queueDepth):0]        occupancy_o,
   output logic                               overflow_o,
   output logic [31:0]                        stallCycles_o,
   output logic [31:0]                        emptyCycles_o
);
   localparam int PW = $clog2(queueDepth);
   localparam int CW = PW + 1;
   localparam int DW = instructionWidth + fetchingAddressWidth + PidSize + TidSize + instructionCounterWidth;

   logic [PW-1:0] r_head, r_tail;
   logic [CW-1:0] r_occ, w_req, w_pops, w_free, w_push, w_acc;
   logic          r_ovf, w_drop, w_we0, w_we1;
   logic [DW-1:0] w_wd0, w_wd1, w_rd0, w_rd1;

   // Space is counted after this cycle's pops, so a full queue can push while draining.
   always_comb begin
      w_req  = decodePop_i[1] ? CW'(2) : CW'(decodePop_i);
      w_pops = (w_req > r_occ) ? r_occ : w_req;
      w_free = CW'(queueDepth) - r_occ + w_pops;
      w_push = CW'(fetchEnable1_i) + CW'(fetchEnable2_i);
      w_acc  = (w_push > w_free) ? w_free : w_push;
      w_drop = !flush_i && (w_push > w_free);
      w_we0  = !flush_i && (w_acc != '0);
      w_we1  = !flush_i && (w_acc == CW'(2));
      w_wd1  = {fetchedInstruction2_i, fetchedAddress2_i, fetchedPid2_i, fetchedTid2_i, fetchedInstMajorId2_i};
      w_wd0  = fetchEnable1_i ? {fetchedInstruction1_i, fetchedAddress1_i, fetchedPid1_i, fetchedTid1_i, fetchedInstMajorId1_i} : w_wd1;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
         r_ovf  <= 1'b0;
      end else if (flush_i) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         r_head <= r_head + PW'(w_pops);
         r_tail <= r_tail + PW'(w_acc);
         r_occ  <= r_occ - w_pops + w_acc;
         r_ovf  <= r_ovf | w_drop;
      end
   end

   fetch_queue_storage #(.DEPTH(queueDepth), .DW(DW)) u_storage (
      .i_clk (clock_i),
      .i_we0 (w_we0),
      .i_we1 (w_we1),
      .i_wa0 (r_tail),
      .i_wa1 (r_tail + PW'(1)),
      .i_wd0 (w_wd0),
      .i_wd1 (w_wd1),
      .i_ra0 (r_head),
      .i_ra1 (r_head + PW'(1)),
      .o_rd0 (w_rd0),
      .o_rd1 (w_rd1)
   );

   assign decodeValid1_o = (r_occ != '0);
   assign decodeValid2_o = (r_occ > CW'(1));
   assign {decodeInstruction1_o, decodeAddress1_o, decodePid1_o, decodeTid1_o, decodeInstMajorId1_o} = decodeValid1_o ? w_rd0 : '0;
   assign {decodeInstruction2_o, decodeAddress2_o, decodePid2_o, decodeTid2_o, decodeInstMajorId2_o} = decodeValid2_o ? w_rd1 : '0;
   assign fetchStall_o   = (CW'(queueDepth) - r_occ) <= CW'(stallThreshold);
   assign occupancy_o    = r_occ;
   assign overflow_o     = r_ovf;

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] r_stall_cnt, r_empty_cnt;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_stall_cnt <= '0;
         r_empty_cnt <= '0;
      end else begin
         r_stall_cnt <= r_stall_cnt + 32'(fetchStall_o);
         r_empty_cnt <= r_empty_cnt + 32'(r_occ == '0);
      end
   end

   assign stallCycles_o = r_stall_cnt;
   assign emptyCycles_o = r_empty_cnt;
`else
   assign stallCycles_o = '0;
   assign emptyCycles_o = '0;
`endif
endmodule

// File: tb/tb_l1i_fetch_queue.sv
// tb_l1i_fetch_queue: directed self-checking bench for l1i_fetch_queue (default 16-entry build).
module tb_l1i_fetch_queue;
   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, e1 = 1'b0, e2 = 1'b0;
   logic [31:0] ins1, ins2, di1, di2;
   logic [63:0] a1, a2, da1, da2, m1, m2, dm1, dm2;
   logic [19:0] p1, p2, dp1, dp2;
   logic [15:0] t1, t2, dt1, dt2;
   logic [1:0]  pop = 2'd0;
   logic        stall, dv1, dv2, ovf;
   logic [4:0]  occ;
   logic [31:0] sc, ec, e0;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   l1i_fetch_queue dut (
      .clock_i(clk), .reset_i(rst), .flush_i(flush),
      .fetchEnable1_i(e1), .fetchEnable2_i(e2),
      .fetchedInstruction1_i(ins1), .fetchedInstruction2_i(ins2),
      .fetchedAddress1_i(a1), .fetchedAddress2_i(a2),
      .fetchedPid1_i(p1), .fetchedPid2_i(p2),
      .fetchedTid1_i(t1), .fetchedTid2_i(t2),
      .fetchedInstMajorId1_i(m1), .fetchedInstMajorId2_i(m2),
      .fetchStall_o(stall), .decodePop_i(pop),
      .decodeValid1_o(dv1), .decodeValid2_o(dv2),
      .decodeInstruction1_o(di1), .decodeInstruction2_o(di2),
      .decodeAddress1_o(da1), .decodeAddress2_o(da2),
      .decodePid1_o(dp1), .decodePid2_o(dp2),
      .decodeTid1_o(dt1), .decodeTid2_o(dt2),
      .decodeInstMajorId1_o(dm1), .decodeInstMajorId2_o(dm2),
      .occupancy_o(occ), .overflow_o(ovf),
      .stallCycles_o(sc), .emptyCycles_o(ec)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Side fields are derived from the address so head contents can be checked end to end.
   task automatic step(input logic en1, input logic en2, input logic [63:0] ad1, input logic [63:0] ad2,
                       input logic [1:0] pp, input logic fl);
      e1 = en1; e2 = en2; pop = pp; flush = fl;
      a1 = ad1; a2 = ad2;
      ins1 = ad1[31:0] ^ 32'hA5A5_0000; ins2 = ad2[31:0] ^ 32'hA5A5_0000;
      p1 = ad1[19:0] + 20'd1; p2 = ad2[19:0] + 20'd1;
      t1 = ad1[15:0] + 16'd2; t2 = ad2[15:0] + 16'd2;
      m1 = ad1 + 64'd3; m2 = ad2 + 64'd3;
      @(posedge clk); #1;
      e1 = 1'b0; e2 = 1'b0; pop = 2'd0; flush = 1'b0;
   endtask

   initial begin
      step(0, 0, 0, 0, 0, 0);
      chk("rst_occ", 64'(occ), 0);
      chk("rst_v1", 64'(dv1), 0);
      chk("rst_v2", 64'(dv2), 0);
      chk("rst_stall", 64'(stall), 0);
      chk("rst_ovf", 64'(ovf), 0);
      chk("rst_addr1", da1, 0);
      rst = 1'b0;
      step(1, 1, 64'h10, 64'h14, 0, 0);
      chk("push_v1", 64'(dv1), 1);
      chk("push_v2", 64'(dv2), 1);
      chk("push_addr1", da1, 64'h10);
      chk("push_addr2", da2, 64'h14);
      chk("push_occ", 64'(occ), 2);
      chk("push_ins1", 64'(di1), 64'hA5A5_0010);
      chk("push_pid1", 64'(dp1), 64'h11);
      chk("push_tid2", 64'(dt2), 64'h16);
      chk("push_mid2", dm2, 64'h17);
      for (int k = 1; k < 4; k++) step(1, 1, 64'h10 + 64'(8 * k), 64'h14 + 64'(8 * k), 0, 0);
      chk("occ8", 64'(occ), 8);
      chk("stall_occ8", 64'(stall), 0);
      step(1, 1, 64'h30, 64'h34, 0, 0);
      chk("occ10", 64'(occ), 10);
      chk("stall_occ10", 64'(stall), 1);
      for (int k = 5; k < 8; k++) step(1, 1, 64'h10 + 64'(8 * k), 64'h14 + 64'(8 * k), 0, 0);
      chk("full_occ", 64'(occ), 16);
      chk("full_ovf", 64'(ovf), 0);
      step(1, 1, 64'h900, 64'h904, 0, 0);
      chk("drop_occ", 64'(occ), 16);
      chk("drop_ovf", 64'(ovf), 1);
      chk("drop_head", da1, 64'h10);
      step(1, 1, 64'h50, 64'h54, 2'd2, 0);
      chk("pushpop_occ", 64'(occ), 16);
      chk("pushpop_addr1", da1, 64'h18);
      chk("pushpop_addr2", da2, 64'h1C);
      chk("pushpop_ovf", 64'(ovf), 1);
      step(0, 0, 0, 0, 2'd2, 0);
      chk("drain_occ14", 64'(occ), 14);
      chk("drain_addr1", da1, 64'h20);
      chk("drain_stall14", 64'(stall), 1);
      for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 2'd2, 0);
      chk("wrap_occ", 64'(occ), 2);
      chk("wrap_addr1", da1, 64'h50);
      chk("wrap_addr2", da2, 64'h54);
      chk("wrap_stall", 64'(stall), 0);
      step(0, 0, 0, 0, 2'd3, 0);
      chk("pop3_occ", 64'(occ), 0);
      chk("pop3_v1", 64'(dv1), 0);
      chk("pop3_addr1", da1, 0);
      step(0, 1, 0, 64'h40, 0, 0);
      chk("slot2_occ", 64'(occ), 1);
      chk("slot2_addr1", da1, 64'h40);
      chk("slot2_pid1", 64'(dp1), 64'h41);
      chk("slot2_v2", 64'(dv2), 0);
      chk("slot2_addr2", da2, 0);
      step(0, 0, 0, 0, 2'd2, 0);
      chk("popover_occ", 64'(occ), 0);
      step(1, 1, 64'h60, 64'h64, 2'd1, 0);
      chk("emptypop_occ", 64'(occ), 2);
      chk("emptypop_addr1", da1, 64'h60);
      for (int k = 0; k < 3; k++) step(1, 1, 64'h68 + 64'(8 * k), 64'h6C + 64'(8 * k), 0, 0);
      chk("preflush_occ", 64'(occ), 8);
      step(1, 1, 64'h80, 64'h84, 2'd2, 1);
      chk("flush_occ", 64'(occ), 0);
      chk("flush_v1", 64'(dv1), 0);
      chk("flush_ovf", 64'(ovf), 1);
      chk("flush_stall", 64'(stall), 0);
`ifdef FETCH_QUEUE_PERF_EN
      e0 = ec;
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("perf_empty", 64'(ec), 64'(e0 + 32'd2));
`else
      chk("perf_stall_tied", 64'(sc), 0);
      chk("perf_empty_tied", 64'(ec), 0);
`endif
      step(1, 1, 64'h90, 64'h94, 0, 0);
      chk("postflush_addr1", da1, 64'h90);
      chk("postflush_addr2", da2, 64'h94);
      #2 rst = 1'b1;
      #1;
      chk("arst_occ", 64'(occ), 0);
      chk("arst_v1", 64'(dv1), 0);
      chk("arst_addr1", da1, 0);
      chk("arst_ovf", 64'(ovf), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
